// File: rtl/uart_receiver_fsm.sv
// 8E1 UART receiver: start, 8 data bits LSB first, even parity, one stop bit.
// Define UART_PARITY_CHECK_EN to drive parity_err; otherwise the parity slot is consumed and parity_err stays 0.
//
// state     | meaning
// IDLE      | line idle, waiting for a low level
// START     | confirming the start bit at its midpoint
// DATA      | shifting in 8 data bits
// PARITY    | consuming the parity bit slot
// STOP      | sampling the stop bit
// WAIT_IDLE | framing error seen, waiting for the line to return high
module uart_receiver_fsm #(
  parameter int unsigned CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       Rxin,
  output logic [7:0] Dout,
  output logic       Dvalid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned HALF      = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0]  BIT_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0]  HALF_LAST = 8'((HALF == 0) ? 0 : HALF - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] dout_q, dout_d;
  logic       dvalid_q, dvalid_d;
  logic       ferr_q, ferr_d;
  logic       tick;

  // cnt_q is a down-counter to the next sample point; zero means sample now
  assign tick = (cnt_q == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      dout_q   <= 8'd0;
      dvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      ferr_q   <= ferr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    ferr_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (!Rxin) begin
          bit_d = 3'd0;
          // with HALF=0 the detection edge already is the start-bit midpoint
          if (HALF == 0) begin
            state_d = DATA;
            cnt_d   = BIT_LAST;
          end else begin
            state_d = START;
            cnt_d   = HALF_LAST;
          end
        end
      end
      START: begin
        if (tick) begin
          if (!Rxin) begin
            state_d = DATA;
            cnt_d   = BIT_LAST;
          end else begin
            state_d = IDLE;
            cnt_d   = 8'd0;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {Rxin, shift_q[7:1]};
          cnt_d   = BIT_LAST;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      PARITY: begin
        if (tick) begin
          cnt_d   = BIT_LAST;
          state_d = STOP;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STOP: begin
        if (tick) begin
          cnt_d = 8'd0;
          if (Rxin) begin
            dout_d   = shift_q;
            dvalid_d = 1'b1;
            state_d  = IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      WAIT_IDLE: begin
        if (Rxin) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

`ifdef UART_PARITY_CHECK_EN
  logic par_q;
  logic perr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      if (state_q == PARITY && tick) par_q <= Rxin;
      // even parity: data plus parity bit must hold an even number of ones
      perr_q <= (state_q == STOP && tick && Rxin) ? ^{shift_q, par_q} : 1'b0;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

  always_comb begin
    Dout      = dout_q;
    Dvalid    = dvalid_q;
    frame_err = ferr_q;
    busy      = (state_q != IDLE);
  end

endmodule

// File: tb/tb_uart_receiver_fsm.sv
// Scoreboard bench for uart_receiver_fsm: one instance at CLKS_PER_BIT=1, one at 4.
module tb_uart_receiver_fsm;

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
    logic       perr;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst1, rst4;
  logic       rx1, rx4;
  logic [7:0] dout1, dout4;
  logic       dv1, dv4, pe1, pe4, fe1, fe4, busy1, busy4;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   start_cyc;
  evt_t q1[$];
  evt_t q4[$];
  int   dv_cyc1[$];

`ifdef UART_PARITY_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  uart_receiver_fsm #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst1), .Rxin(rx1), .Dout(dout1), .Dvalid(dv1),
    .parity_err(pe1), .frame_err(fe1), .busy(busy1)
  );

  uart_receiver_fsm #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst(rst4), .Rxin(rx4), .Dout(dout4), .Dvalid(dv4),
    .parity_err(pe4), .frame_err(fe4), .busy(busy4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int which, input logic v, input int n);
    if (which == 1) rx1 = v;
    else rx4 = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int which, input logic [7:0] d, input logic p,
                      input logic s, input int cpb);
    drive(which, 1'b0, cpb);
    for (int i = 0; i < 8; i++) drive(which, d[i], cpb);
    drive(which, p, cpb);
    drive(which, s, cpb);
  endtask

  task automatic mon_one(input string tag, input logic dv, input logic fe, input logic pe,
                         input logic [7:0] dout, inout evt_t q[$]);
    evt_t e;
    if (dv || fe || pe) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s_unexpected_pulse: got dv=%0b fe=%0b pe=%0b expected none", tag, dv, fe, pe);
      end else begin
        e = q.pop_front();
        check({tag, "_dvalid"}, 32'(dv), 32'(!e.ferr));
        check({tag, "_frame_err"}, 32'(fe), 32'(e.ferr));
        check({tag, "_parity_err"}, 32'(pe), 32'(e.perr));
        check({tag, "_dout"}, 32'(dout), 32'(e.data));
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q4.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_q1", 32'(q1.size()), 32'd0);
    check("drain_q4", 32'(q4.size()), 32'd0);
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; rx1 = 1'b1; rx4 = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (dv1) dv_cyc1.push_back(cyc);
        mon_one("d1", dv1, fe1, pe1, dout1, q1);
        mon_one("d4", dv4, fe4, pe4, dout4, q4);
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    check("rst_dout1", 32'(dout1), 32'h00);
    check("rst_pulses1", 32'({dv1, pe1, fe1}), 32'd0);
    check("rst_busy1", 32'(busy1), 32'd0);
    check("rst_dout4", 32'(dout4), 32'h00);
    check("rst_busy4", 32'(busy4), 32'd0);
    rst1 = 1'b0; rst4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 8'h38, three ones, parity 1
    q1.push_back('{ferr: 1'b0, data: 8'h38, perr: 1'b0});
    start_cyc = cyc;
    send(1, 8'h38, 1'b1, 1'b1, 1);
    wait_drain(20);
    check("latency_38", 32'(dv_cyc1[0] - start_cyc), 32'd11);
    drive(1, 1'b1, 3);

    // back-to-back frames with no idle cycle between them
    q1.push_back('{ferr: 1'b0, data: 8'hF0, perr: 1'b0});
    q1.push_back('{ferr: 1'b0, data: 8'hCC, perr: 1'b0});
    send(1, 8'hF0, 1'b0, 1'b1, 1);
    send(1, 8'hCC, 1'b0, 1'b1, 1);
    wait_drain(20);
    check("b2b_count", 32'(dv_cyc1.size()), 32'd3);
    if (dv_cyc1.size() == 3) check("b2b_spacing", 32'(dv_cyc1[2] - dv_cyc1[1]), 32'd11);
    drive(1, 1'b1, 3);

    // 8'hE8 has four ones; parity bit 1 is wrong
    q1.push_back('{ferr: 1'b0, data: 8'hE8, perr: PERR_EXP});
    send(1, 8'hE8, 1'b1, 1'b1, 1);
    wait_drain(20);
    drive(1, 1'b1, 3);

    // bad stop bit, line held low afterwards
    q1.push_back('{ferr: 1'b1, data: 8'hE8, perr: 1'b0});
    send(1, 8'h55, 1'b0, 1'b0, 1);
    for (int i = 0; i < 5; i++) begin
      check("ferr_busy_low", 32'(busy1), 32'd1);
      drive(1, 1'b0, 1);
    end
    check("ferr_dout_kept", 32'(dout1), 32'hE8);
    drive(1, 1'b1, 1);
    check("ferr_idle_after_high", 32'(busy1), 32'd0);
    drive(1, 1'b1, 3);
    check("ferr_no_new_frame", 32'(busy1), 32'd0);
    wait_drain(5);

    // one-clock glitch at CLKS_PER_BIT=4 must be rejected at the midpoint
    drive(4, 1'b0, 1);
    check("glitch_busy", 32'(busy4), 32'd1);
    drive(4, 1'b1, 1);
    check("glitch_rejected", 32'(busy4), 32'd0);
    drive(4, 1'b1, 3);
    check("glitch_still_idle", 32'(busy4), 32'd0);

    q4.push_back('{ferr: 1'b0, data: 8'hA5, perr: 1'b0});
    send(4, 8'hA5, 1'b0, 1'b1, 4);
    wait_drain(20);
    check("a5_dout", 32'(dout4), 32'hA5);
    drive(4, 1'b1, 4);

    // reset during data bit 3 abandons the frame
    drive(4, 1'b0, 4);
    drive(4, 1'b1, 4);
    drive(4, 1'b1, 4);
    drive(4, 1'b0, 4);
    drive(4, 1'b0, 1);
    check("midrst_busy_before", 32'(busy4), 32'd1);
    rst4 = 1'b1;
    @(posedge clk);
    #1;
    rst4 = 1'b0;
    rx4  = 1'b1;
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_pulses", 32'({dv4, pe4, fe4}), 32'd0);
    check("midrst_dout", 32'(dout4), 32'h00);
    repeat (50) @(posedge clk);
    #1;
    check("midrst_idle_later", 32'(busy4), 32'd0);
    wait_drain(5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
